// File: rtl/alu_cmd_sequencer_if.sv
// Command-in / result-out handshake bundle for alu_cmd_sequencer.
// Optional feature macro: STATUS_FLAGS_EN adds out_zero / out_parity.
interface alu_cmd_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] in_sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic [2:0] out_sel;
`ifdef STATUS_FLAGS_EN
  logic       out_zero;
  logic       out_parity;

  modport master (
    output in_valid, in_a, in_b, in_sel, out_ready,
    input  in_ready, out_valid, out_result, out_sel, out_zero, out_parity
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sel, out_ready,
    output in_ready, out_valid, out_result, out_sel, out_zero, out_parity
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_sel, out_ready,
    input  in_ready, out_valid, out_result, out_sel
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sel, out_ready,
    output in_ready, out_valid, out_result, out_sel
  );
`endif
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for an 8-bit combinational ALU: a small command FIFO drives the
// ALU operands from its head entry, and the ALU result is captured into a
// valid/ready output register.
// Optional feature macro: STATUS_FLAGS_EN (registered out_zero / out_parity).
module alu_cmd_sequencer #(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  alu_cmd_sequencer_if.slave    bus,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic [2:0]            alu_sel,
  input  logic [7:0]            alu_result,
  output logic [CW-1:0]         level
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    r_mem_a   [DEPTH];
  logic [7:0]    r_mem_b   [DEPTH];
  logic [2:0]    r_mem_sel [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_level;
  logic          r_out_valid;
  logic [7:0]    r_out_result;
  logic [2:0]    r_out_sel;
`ifdef STATUS_FLAGS_EN
  logic          r_out_zero;
  logic          r_out_parity;
`endif

  logic w_not_empty;
  logic w_in_ready;
  logic w_push;
  logic w_pop;

  // Handshake decode; in_ready looks only at stored occupancy, never at pop.
  always_comb begin
    w_not_empty = (r_level != '0);
    w_in_ready  = rst_n & (r_level != CW'(DEPTH)) & ~flush;
    w_push      = bus.in_valid & w_in_ready;
    w_pop       = w_not_empty & (~r_out_valid | bus.out_ready) & ~flush;
  end

  // Command storage; contents are don't-care until counted by r_level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr]   <= bus.in_a;
      r_mem_b[r_wr_ptr]   <= bus.in_b;
      r_mem_sel[r_wr_ptr] <= bus.in_sel;
    end
  end

  // Head entry drives the ALU; an empty FIFO presents all zeros.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = '0;
    if (w_not_empty) begin
      alu_a   = r_mem_a[r_rd_ptr];
      alu_b   = r_mem_b[r_rd_ptr];
      alu_sel = r_mem_sel[r_rd_ptr];
    end
  end

  // Pointers, occupancy and output register; flush outranks push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_sel    <= '0;
`ifdef STATUS_FLAGS_EN
      r_out_zero   <= 1'b0;
      r_out_parity <= 1'b0;
`endif
    end else if (flush) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_sel    <= '0;
`ifdef STATUS_FLAGS_EN
      r_out_zero   <= 1'b0;
      r_out_parity <= 1'b0;
`endif
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + 1'b1;
        r_out_valid  <= 1'b1;
        r_out_result <= alu_result;
        r_out_sel    <= r_mem_sel[r_rd_ptr];
`ifdef STATUS_FLAGS_EN
        r_out_zero   <= (alu_result == '0);
        r_out_parity <= ^alu_result;
`endif
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Port drive from registered state.
  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_result = r_out_result;
  assign bus.out_sel    = r_out_sel;
`ifdef STATUS_FLAGS_EN
  assign bus.out_zero   = r_out_zero;
  assign bus.out_parity = r_out_parity;
`endif
  assign level          = r_level;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with a behavioural ALU.
// ALU opcodes used here: 000 add, 001 sub, 010 and, 011 or, 100 xor,
// 101 nand, 110 shl by b[2:0], 111 shr by b[2:0].
module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic [2:0]    alu_sel;
  logic [7:0]    alu_result;
  logic [CW-1:0] level;

  int n_checks;
  int n_fail;

  alu_cmd_sequencer_if bus ();

  alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU on the return path.
  always_comb begin
    case (alu_sel)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = alu_a ^ alu_b;
      3'b101:  alu_result = ~(alu_a & alu_b);
      3'b110:  alu_result = alu_a << alu_b[2:0];
      default: alu_result = alu_a >> alu_b[2:0];
    endcase
  end

  typedef struct {
    logic [2:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = v;
    bus.in_sel   = s;
    bus.in_a     = a;
    bus.in_b     = b;
  endtask

  logic [7:0] bp_exp [5];
  int         vcnt;

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{3'b000, 8'h0F, 8'h01, 8'h10};
    vecs[1] = '{3'b001, 8'h00, 8'h01, 8'hFF};
    vecs[2] = '{3'b010, 8'hF0, 8'h3C, 8'h30};
    vecs[3] = '{3'b011, 8'h0F, 8'h30, 8'h3F};
    vecs[4] = '{3'b100, 8'hAA, 8'hFF, 8'h55};
    vecs[5] = '{3'b000, 8'hFF, 8'h02, 8'h01};
    vecs[6] = '{3'b110, 8'h81, 8'h01, 8'h02};
    vecs[7] = '{3'b111, 8'h80, 8'h07, 8'h01};

    bp_exp[0] = 8'h11; bp_exp[1] = 8'h12; bp_exp[2] = 8'h13;
    bp_exp[3] = 8'h14; bp_exp[4] = 8'h15;

    rst_n = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    #2;
    chk("reset_in_ready", 32'(bus.in_ready), 0);
    tick();
    tick();
    chk("reset_level", 32'(level), 0);
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_out_result", 32'(bus.out_result), 0);
    chk("reset_alu_a", 32'(alu_a), 0);
    rst_n = 1'b1;
    #1;
    chk("post_reset_in_ready", 32'(bus.in_ready), 1);

    // Single commands through the table: push, capture one cycle later.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].sel, vecs[i].a, vecs[i].b);
      tick();
      drive(1'b0, 3'b000, 8'h00, 8'h00);
      chk("vec_level_after_push", 32'(level), 1);
      chk("vec_alu_sel", 32'(alu_sel), 32'(vecs[i].sel));
      chk("vec_out_valid_early", 32'(bus.out_valid), 0);
      tick();
      chk("vec_out_valid", 32'(bus.out_valid), 1);
      chk("vec_out_result", 32'(bus.out_result), 32'(vecs[i].exp));
      chk("vec_out_sel", 32'(bus.out_sel), 32'(vecs[i].sel));
      chk("vec_level_after_pop", 32'(level), 0);
`ifdef STATUS_FLAGS_EN
      chk("vec_out_zero", 32'(bus.out_zero), 32'(vecs[i].exp == 8'h00));
      chk("vec_out_parity", 32'(bus.out_parity), 32'(^vecs[i].exp));
`endif
      tick();
      chk("vec_out_valid_drop", 32'(bus.out_valid), 0);
    end

    // Reset mid-stream with three commands queued behind a held result.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'b000, 8'(i), 8'h01);
      tick();
    end
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    chk("midreset_level_before", 32'(level), 3);
    chk("midreset_valid_before", 32'(bus.out_valid), 1);
    rst_n = 1'b0;
    #2;
    chk("midreset_level", 32'(level), 0);
    chk("midreset_out_valid", 32'(bus.out_valid), 0);
    chk("midreset_in_ready", 32'(bus.in_ready), 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("midreset_release_in_ready", 32'(bus.in_ready), 1);
    tick();
    chk("midreset_release_level", 32'(level), 0);

    // Backpressure: five pushes plus one refused attempt, then ordered drain.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'b000, 8'(8'h10 + i), 8'h01);
      tick();
    end
    chk("bp_level_full", 32'(level), 4);
    chk("bp_in_ready", 32'(bus.in_ready), 0);
    chk("bp_held_result", 32'(bus.out_result), 32'(bp_exp[0]));
    drive(1'b1, 3'b000, 8'h77, 8'h01);
    tick();
    chk("bp_level_stays_full", 32'(level), 4);
    chk("bp_held_result_stable", 32'(bus.out_result), 32'(bp_exp[0]));
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_drain_valid", 32'(bus.out_valid), 1);
      chk("bp_drain_result", 32'(bus.out_result), 32'(bp_exp[i]));
      tick();
    end
    chk("bp_drain_done_valid", 32'(bus.out_valid), 0);
    chk("bp_drain_done_level", 32'(level), 0);

    // Throughput: eight back-to-back ANDs, one result per cycle.
    vcnt = 0;
    for (int i = 0; i < 11; i++) begin
      if (i < 8) drive(1'b1, 3'b010, 8'hF0, 8'h3C);
      else       drive(1'b0, 3'b000, 8'h00, 8'h00);
      tick();
      chk("tp_level_le1", 32'(level <= 1), 1);
      if (bus.out_valid) begin
        vcnt++;
        chk("tp_result", 32'(bus.out_result), 32'h30);
      end
    end
    chk("tp_valid_cycles", 32'(vcnt), 8);

    // Flush with level 2 and a held result; the concurrent push is dropped.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'b011, 8'h01, 8'h02);
      tick();
    end
    chk("flush_level_before", 32'(level), 2);
    chk("flush_valid_before", 32'(bus.out_valid), 1);
    flush = 1'b1;
    drive(1'b1, 3'b100, 8'h55, 8'h55);
    #1;
    chk("flush_in_ready", 32'(bus.in_ready), 0);
    tick();
    flush = 1'b0;
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    chk("flush_level", 32'(level), 0);
    chk("flush_out_valid", 32'(bus.out_valid), 0);
    chk("flush_out_result", 32'(bus.out_result), 0);
    chk("flush_out_sel", 32'(bus.out_sel), 0);
    chk("flush_alu_a", 32'(alu_a), 0);
    tick();
    chk("flush_no_accept_level", 32'(level), 0);
    chk("flush_no_accept_valid", 32'(bus.out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
